// File: rtl/fifo_wr_arb.sv
// Packet-granular round-robin arbiter for the write port of the host-bound FIFO.
// A grant is issued only with enough FIFO free space and is held until the packet's last word.
module fifo_wr_arb #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 10,
  parameter int WORDS_TOTAL = 2**ADDR_W,
  parameter int FREE_MIN    = 16
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic                      fifo_wen,
  input  logic                      fifo_wfull,
  input  logic [ADDR_W:0]           fifo_wload,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      pkt_done,
  output logic [15:0]               pkt_len
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int LW   = ADDR_W + 1;
  localparam logic [LW-1:0] TOTAL = LW'(WORDS_TOTAL);
  localparam logic [LW-1:0] FMIN  = LW'(FREE_MIN);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   cand, sel_id;
  logic              sel_found;
  logic [LW-1:0]     free;
  logic [15:0]       cnt, cnt_inc;
  logic              gvalid, glast;
  logic [DATA_W-1:0] gdata;
  logic              grant_go, xfer;

  // Walk sources starting after the last grant, wrapping at N_REQ-1 (N_REQ need not be a power of 2).
  always_comb begin
    cand      = last_grant;
    sel_id    = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + ID_W'(1);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  always_comb begin
    free = (fifo_wload >= TOTAL) ? '0 : TOTAL - fifo_wload;
  end

  always_comb begin
    gvalid = 1'b0;
    glast  = 1'b0;
    gdata  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        gvalid = req_valid[i];
        glast  = req_last[i];
        gdata  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cnt_inc    = (cnt == '1) ? cnt : cnt + 16'd1;
  assign fifo_wdata = gdata;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    fifo_wen  = 1'b0;
    busy      = 1'b0;
    grant_go  = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found && free >= FMIN) begin
          grant_go  = 1'b1;
          state_nxt = BURST;
        end
      end
      BURST: begin
        busy = 1'b1;
        for (int unsigned i = 0; i < N_REQ; i++) begin
          req_ready[i] = (grant_id == ID_W'(i)) && !fifo_wfull;
        end
        fifo_wen = gvalid;
        xfer     = gvalid && !fifo_wfull;
        if (xfer && glast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      grant_id   <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      cnt        <= '0;
      pkt_done   <= 1'b0;
      pkt_len    <= '0;
    end else begin
      pkt_done <= xfer && glast;
      if (grant_go) begin
        grant_id   <= sel_id;
        last_grant <= sel_id;
        cnt        <= '0;
      end else if (xfer) begin
        cnt <= cnt_inc;
      end
      if (xfer && glast) pkt_len <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: behavioural packet sources, a FIFO write capture
// and per-scenario checks against hand-computed sequences.
module tb_fifo_wr_arb;

  logic        wclk = 1'b0;
  logic        wrst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  fifo_wdata;
  logic        fifo_wen;
  logic        fifo_wfull;
  logic [10:0] fifo_wload;
  logic        busy;
  logic [1:0]  grant_id;
  logic        pkt_done;
  logic [15:0] pkt_len;

  fifo_wr_arb #(.N_REQ(4), .DATA_W(8), .ADDR_W(10), .WORDS_TOTAL(1024), .FREE_MIN(16)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wdata(fifo_wdata),
    .fifo_wen(fifo_wen), .fifo_wfull(fifo_wfull), .fifo_wload(fifo_wload),
    .busy(busy), .grant_id(grant_id), .pkt_done(pkt_done), .pkt_len(pkt_len)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  // Source model: src_pkts packets of src_len words; data = {id, seq[5:0]};
  // optional valid gap of src_gap_left cycles when the word index reaches src_gap_at.
  int src_len[4], src_pkts[4], src_word[4], src_seq[4], src_gap_at[4], src_gap_left[4];

  int         cyc;
  logic       busy_tr  [0:63];
  logic [3:0] ready_tr [0:63];
  logic [1:0] gid_tr   [0:63];
  logic [7:0] wr_q[$];
  int         wc_q[$];
  int         done_gid[$], done_len[$], done_cyc[$];

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (src_pkts[i] > 0) && !(src_word[i] == src_gap_at[i] && src_gap_left[i] > 0);
      req_last[i]  = (src_word[i] == src_len[i] - 1);
      req_data[i*8 +: 8] = 8'((i << 6) | (src_seq[i] & 63));
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 1; src_pkts[i] = 0; src_word[i] = 0; src_seq[i] = 0;
      src_gap_at[i] = 255; src_gap_left[i] = 0;
    end
    drive();
  endtask

  task automatic clear_logs();
    cyc = 0;
    wr_q.delete(); wc_q.delete();
    done_gid.delete(); done_len.delete(); done_cyc.delete();
  endtask

  task automatic tick();
    logic [3:0] fire;
    @(negedge wclk);
    if (cyc < 64) begin
      busy_tr[cyc] = busy; ready_tr[cyc] = req_ready; gid_tr[cyc] = grant_id;
    end
    fire = req_valid & req_ready;
    if (fifo_wen && !fifo_wfull) begin
      wr_q.push_back(fifo_wdata);
      wc_q.push_back(cyc);
    end
    if (pkt_done) begin
      done_gid.push_back(int'(grant_id));
      done_len.push_back(int'(pkt_len));
      done_cyc.push_back(cyc);
    end
    @(posedge wclk); #1;
    for (int i = 0; i < 4; i++) begin
      if (fire[i]) begin
        src_seq[i]++;
        if (src_word[i] == src_len[i] - 1) begin
          src_word[i] = 0;
          src_pkts[i]--;
        end else begin
          src_word[i]++;
        end
      end else if (src_pkts[i] > 0 && src_word[i] == src_gap_at[i] && src_gap_left[i] > 0) begin
        src_gap_left[i]--;
      end
    end
    cyc++;
    drive();
  endtask

  task automatic do_reset();
    wrst = 1'b1; fifo_wfull = 1'b0; fifo_wload = '0;
    clear_srcs();
    repeat (2) @(posedge wclk);
    #1 wrst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    wrst = 1'b1; fifo_wfull = 1'b0; fifo_wload = '0;
    clear_srcs();
    src_pkts[1] = 1; src_len[1] = 2;
    drive();
    repeat (2) @(posedge wclk);
    #1;
    if (busy !== 1'b0) begin $display("FAIL rst_busy got %b want 0", busy); errors++; end
    checks++;
    if (grant_id !== 2'd0) begin $display("FAIL rst_grant_id got %0d want 0", grant_id); errors++; end
    checks++;
    if (pkt_done !== 1'b0) begin $display("FAIL rst_pkt_done got %b want 0", pkt_done); errors++; end
    checks++;
    if (pkt_len !== 16'd0) begin $display("FAIL rst_pkt_len got %0d want 0", pkt_len); errors++; end
    checks++;
    if (req_ready !== 4'b0000) begin $display("FAIL rst_req_ready got %b want 0000", req_ready); errors++; end
    checks++;
    if (fifo_wen !== 1'b0) begin $display("FAIL rst_fifo_wen got %b want 0", fifo_wen); errors++; end
    checks++;
    wrst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] exp_d [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
    do_reset();
    src_pkts[0] = 1; src_len[0] = 4;
    drive();
    repeat (8) tick();
    if (busy_tr[0] !== 1'b0) begin $display("FAIL single_busy_t got %b want 0", busy_tr[0]); errors++; end
    checks++;
    if (busy_tr[1] !== 1'b1) begin $display("FAIL single_busy_t1 got %b want 1", busy_tr[1]); errors++; end
    checks++;
    if (wr_q.size() !== 4) begin $display("FAIL single_wcount got %0d want 4", wr_q.size()); errors++; end
    checks++;
    for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
      if (wr_q[k] !== exp_d[k] || wc_q[k] !== k + 1) begin
        $display("FAIL single_word%0d got %h@%0d want %h@%0d", k, wr_q[k], wc_q[k], exp_d[k], k + 1);
        errors++;
      end
      checks++;
    end
    if (done_gid.size() !== 1 || done_len[0] !== 4 || done_gid[0] !== 0 || done_cyc[0] !== 5) begin
      $display("FAIL single_done got n=%0d len=%0d gid=%0d cyc=%0d want n=1 len=4 gid=0 cyc=5",
               done_gid.size(), done_len[0], done_gid[0], done_cyc[0]);
      errors++;
    end
    checks++;
    if (busy_tr[5] !== 1'b0) begin $display("FAIL single_busy_after got %b want 0", busy_tr[5]); errors++; end
    checks++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [18] = '{8'h00, 8'h01, 8'h02, 8'h40, 8'h41, 8'h42, 8'h80, 8'h81, 8'h82,
                               8'h03, 8'h04, 8'h05, 8'h43, 8'h44, 8'h45, 8'h83, 8'h84, 8'h85};
    int exp_g [6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int i = 0; i < 3; i++) begin src_pkts[i] = 2; src_len[i] = 3; end
    drive();
    repeat (28) tick();
    if (wr_q.size() !== 18) begin $display("FAIL rr_wcount got %0d want 18", wr_q.size()); errors++; end
    checks++;
    for (int k = 0; k < 18 && k < wr_q.size(); k++) begin
      if (wr_q[k] !== exp_d[k]) begin
        $display("FAIL rr_word%0d got %h want %h", k, wr_q[k], exp_d[k]); errors++;
      end
      checks++;
    end
    if (done_gid.size() !== 6) begin $display("FAIL rr_dcount got %0d want 6", done_gid.size()); errors++; end
    checks++;
    for (int k = 0; k < 6 && k < done_gid.size(); k++) begin
      if (done_gid[k] !== exp_g[k] || done_len[k] !== 3 || done_cyc[k] !== 4 * k + 4) begin
        $display("FAIL rr_done%0d got gid=%0d len=%0d cyc=%0d want gid=%0d len=3 cyc=%0d",
                 k, done_gid[k], done_len[k], done_cyc[k], exp_g[k], 4 * k + 4);
        errors++;
      end
      checks++;
    end
  endtask

  task automatic test_hold();
    logic [7:0] exp_d [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hC0, 8'hC1};
    do_reset();
    src_pkts[0] = 1; src_len[0] = 4; src_gap_at[0] = 2; src_gap_left[0] = 5;
    src_pkts[3] = 1; src_len[3] = 2;
    drive();
    repeat (16) tick();
    for (int c = 1; c <= 9; c++) begin
      if (ready_tr[c][3] !== 1'b0 || gid_tr[c] !== 2'd0 || busy_tr[c] !== 1'b1) begin
        $display("FAIL hold_c%0d got rdy3=%b gid=%0d busy=%b want 0 0 1", c, ready_tr[c][3], gid_tr[c], busy_tr[c]);
        errors++;
      end
      checks++;
    end
    if (wr_q.size() !== 6) begin $display("FAIL hold_wcount got %0d want 6", wr_q.size()); errors++; end
    checks++;
    for (int k = 0; k < 6 && k < wr_q.size(); k++) begin
      if (wr_q[k] !== exp_d[k]) begin $display("FAIL hold_word%0d got %h want %h", k, wr_q[k], exp_d[k]); errors++; end
      checks++;
    end
    if (done_gid.size() !== 2 || done_gid[0] !== 0 || done_len[0] !== 4 || done_cyc[0] !== 10
        || done_gid[1] !== 3 || done_len[1] !== 2 || done_cyc[1] !== 13) begin
      $display("FAIL hold_done got n=%0d first=%0d/%0d@%0d want n=2 first=0/4@10 second=3/2@13",
               done_gid.size(), done_gid[0], done_len[0], done_cyc[0]);
      errors++;
    end
    checks++;
  endtask

  task automatic test_free_space();
    do_reset();
    fifo_wload = 11'd1014;
    src_pkts[1] = 1; src_len[1] = 2;
    drive();
    repeat (5) tick();
    fifo_wload = 11'd1009;
    repeat (3) tick();
    fifo_wload = 11'd1008;
    repeat (6) tick();
    for (int c = 0; c <= 8; c++) begin
      if (busy_tr[c] !== 1'b0) begin $display("FAIL free_idle_c%0d got busy=%b want 0", c, busy_tr[c]); errors++; end
      checks++;
    end
    if (busy_tr[9] !== 1'b1 || gid_tr[9] !== 2'd1) begin
      $display("FAIL free_grant got busy=%b gid=%0d want 1 1", busy_tr[9], gid_tr[9]); errors++;
    end
    checks++;
    if (wr_q.size() !== 2 || wr_q[0] !== 8'h40 || wr_q[1] !== 8'h41 || wc_q[0] !== 9) begin
      $display("FAIL free_words got n=%0d %h %h @%0d want n=2 40 41 @9", wr_q.size(), wr_q[0], wr_q[1], wc_q[0]);
      errors++;
    end
    checks++;
    if (done_gid.size() !== 1 || done_len[0] !== 2 || done_cyc[0] !== 11) begin
      $display("FAIL free_done got n=%0d len=%0d cyc=%0d want n=1 len=2 cyc=11", done_gid.size(), done_len[0], done_cyc[0]);
      errors++;
    end
    checks++;
  endtask

  task automatic test_full();
    logic [7:0] exp_d [5] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84};
    int exp_c [5] = '{1, 2, 11, 12, 13};
    do_reset();
    src_pkts[2] = 1; src_len[2] = 5;
    drive();
    repeat (3) tick();
    fifo_wfull = 1'b1;
    repeat (8) tick();
    fifo_wfull = 1'b0;
    repeat (6) tick();
    for (int c = 3; c <= 10; c++) begin
      if (ready_tr[c] !== 4'b0000 || busy_tr[c] !== 1'b1) begin
        $display("FAIL full_c%0d got rdy=%b busy=%b want 0000 1", c, ready_tr[c], busy_tr[c]); errors++;
      end
      checks++;
    end
    if (wr_q.size() !== 5) begin $display("FAIL full_wcount got %0d want 5", wr_q.size()); errors++; end
    checks++;
    for (int k = 0; k < 5 && k < wr_q.size(); k++) begin
      if (wr_q[k] !== exp_d[k] || wc_q[k] !== exp_c[k]) begin
        $display("FAIL full_word%0d got %h@%0d want %h@%0d", k, wr_q[k], wc_q[k], exp_d[k], exp_c[k]); errors++;
      end
      checks++;
    end
    if (done_gid.size() !== 1 || done_len[0] !== 5 || done_gid[0] !== 2 || done_cyc[0] !== 14) begin
      $display("FAIL full_done got n=%0d len=%0d gid=%0d cyc=%0d want n=1 len=5 gid=2 cyc=14",
               done_gid.size(), done_len[0], done_gid[0], done_cyc[0]);
      errors++;
    end
    checks++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    src_pkts[0] = 1; src_len[0] = 6;
    src_pkts[1] = 1; src_len[1] = 2;
    drive();
    repeat (4) tick();
    if (busy !== 1'b1 || wr_q.size() !== 3) begin
      $display("FAIL midrst_pre got busy=%b n=%0d want 1 3", busy, wr_q.size()); errors++;
    end
    checks++;
    #2 wrst = 1'b1;
    #1;
    if (busy !== 1'b0 || req_ready !== 4'b0000 || fifo_wen !== 1'b0 || grant_id !== 2'd0) begin
      $display("FAIL midrst_async got busy=%b rdy=%b wen=%b gid=%0d want 0 0000 0 0", busy, req_ready, fifo_wen, grant_id);
      errors++;
    end
    checks++;
    @(posedge wclk); #1;
    if (pkt_done !== 1'b0 || pkt_len !== 16'd0 || done_gid.size() !== 0) begin
      $display("FAIL midrst_nodone got done=%b len=%0d n=%0d want 0 0 0", pkt_done, pkt_len, done_gid.size()); errors++;
    end
    checks++;
    wrst = 1'b0;
    clear_srcs();
    clear_logs();
    src_pkts[0] = 1; src_len[0] = 2;
    src_pkts[1] = 1; src_len[1] = 2;
    drive();
    repeat (8) tick();
    if (done_gid.size() !== 2 || done_gid[0] !== 0 || done_gid[1] !== 1) begin
      $display("FAIL midrst_order got n=%0d first=%0d want n=2 0 then 1", done_gid.size(), done_gid[0]); errors++;
    end
    checks++;
    if (wr_q.size() !== 4 || wr_q[0] !== 8'h00 || wr_q[1] !== 8'h01 || wr_q[2] !== 8'h40 || wr_q[3] !== 8'h41) begin
      $display("FAIL midrst_words got n=%0d %h %h want n=4 00 01 40 41", wr_q.size(), wr_q[0], wr_q[1]); errors++;
    end
    checks++;
  endtask

  initial begin
    wrst = 1'b1; fifo_wfull = 1'b0; fifo_wload = '0;
    req_valid = '0; req_data = '0; req_last = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_free_space();
    test_full();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
